// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Takes bytes from a first-word-fall-through TX FIFO and sends each one on the
// UART line as an 8N1 frame: one start bit, NBIT data bits LSB first, and a
// stop period of SB_TICK baud ticks. The baud timing comes from s_tick, which
// pulses OS times per bit period. Between frames the line sits idle high.
//
// Optional feature: when the macro UART_TX_PARITY_EN is defined, an even-parity
// bit goes out between the last data bit and the stop period. When the macro is
// not defined, the parity state is never entered and the frame is plain 8N1.
//
// Ports:
//   CLK         system clock; all logic runs on the rising edge
//   RESET       synchronous, active-high reset
//   s_tick      baud tick, one CLK wide, OS pulses per bit period
//   fifo_empty  TX FIFO empty flag
//   data_fifo   FIFO head word, valid whenever fifo_empty = 0
//   RD_FIFO     pop strobe, one CLK wide, driven combinationally in idle
//   TX          serial output line, idle high
//   tx_done     one-CLK pulse on the final stop tick of each frame
//   STATE       current FSM state for debug (idle=0 start=1 data=2 parity=3 stop=4)
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int NBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [NBIT-1:0] data_fifo,
    output logic            RD_FIFO,
    output logic            TX,
    output logic            tx_done,
    output logic [2:0]      STATE
);

    // The tick counter must hold the largest terminal count, either a bit
    // period or the stop period.
    localparam int TICK_MAX = (SB_TICK > OS) ? SB_TICK : OS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BIT_W    = (NBIT > 1) ? $clog2(NBIT) : 1;

    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OS - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic [BIT_W-1:0]  bit_cnt, bit_next;
    logic [NBIT-1:0]   shift, shift_next;
`ifdef UART_TX_PARITY_EN
    logic              parity, parity_next;
`endif

    assign STATE = state;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge and the order of these
    // statements does not matter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the shift register is cleared along with the control state.
            // This means a truncated frame leaves no stale data behind.
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every value written below gets a default first, so no path
        // through the case statement can infer a latch.
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
`ifdef UART_TX_PARITY_EN
        parity_next = parity;
`endif
        RD_FIFO = 1'b0;
        TX      = 1'b1;
        tx_done = 1'b0;

        case (state)
            ST_IDLE: begin
                // Counters are held at zero here. Any tick during the load
                // cycle is therefore ignored.
                TX        = 1'b1;
                tick_next = '0;
                bit_next  = '0;
                if (!fifo_empty) begin
                    RD_FIFO    = 1'b1;
                    shift_next = data_fifo;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data_fifo;
`endif
                    state_next = ST_START;
                end
            end

            ST_START: begin
                TX = 1'b0;
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = ST_DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                TX = shift[0];
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        shift_next = shift >> 1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                TX = parity;
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_next  = '0;
                        state_next = ST_STOP;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                TX = 1'b1;
                if (s_tick) begin
                    if (tick_cnt == SB_LAST) begin
                        tx_done    = 1'b1;
                        tick_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
            end
        endcase

        // Reset overrides everything, including the combinational strobes.
        if (RESET) begin
            RD_FIFO = 1'b0;
            tx_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Self-checking bench for uart_tx_serializer. The bench models a
// first-word-fall-through FIFO. Each byte queued into that FIFO is also pushed
// onto an expected-byte scoreboard. A line decoder watches TX, counts s_tick
// pulses from the start bit, and samples each bit in the middle of its period.
// It checks the start bit, stop bit, optional parity bit and the timing of the
// tx_done pulse, then pops the scoreboard and compares the decoded byte.
// Inputs are driven 1-2 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int NBIT    = 8;
    localparam int OS      = 16;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_TICKS = OS;
`else
    localparam int PAR_TICKS = 0;
`endif
    localparam int DATA_END    = OS * (1 + NBIT) + PAR_TICKS;
    localparam int FRAME_TICKS = DATA_END + SB_TICK;

    logic            CLK        = 1'b0;
    logic            RESET      = 1'b1;
    logic            s_tick     = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [NBIT-1:0] data_fifo  = '0;
    logic            RD_FIFO;
    logic            TX;
    logic            tx_done;
    logic [2:0]      STATE;

    uart_tx_serializer #(
        .NBIT    (NBIT),
        .OS      (OS),
        .SB_TICK (SB_TICK)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .s_tick     (s_tick),
        .fifo_empty (fifo_empty),
        .data_fifo  (data_fifo),
        .RD_FIFO    (RD_FIFO),
        .TX         (TX),
        .tx_done    (tx_done),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // FIFO model and scoreboard
    logic [NBIT-1:0] fifo_q[$];
    logic [NBIT-1:0] exp_q[$];
    logic            force_empty = 1'b0;
    logic            pop_pending = 1'b0;
    int              tick_div    = 4;
    int              tick_phase  = 0;
    int              rd_cnt      = 0;
    int              done_cnt    = 0;

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        data_fifo  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic send(input logic [NBIT-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        refresh_fifo();
    endtask

    // The pop seen during a cycle is applied after the edge that latched the word.
    always @(posedge CLK) begin
        #1;
        if (pop_pending) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_pending = 1'b0;
        end
        tick_phase++;
        if (tick_phase >= tick_div) begin
            tick_phase = 0;
            s_tick     = 1'b1;
        end else begin
            s_tick = 1'b0;
        end
        refresh_fifo();
    end

    always @(negedge CLK) begin
        if (RD_FIFO) begin
            rd_cnt++;
            pop_pending = 1'b1;
        end
        if (tx_done) done_cnt++;
    end

    // Line decoder
    logic            in_frame    = 1'b0;
    int              tick_n      = 0;
    int              dec_idx     = 0;
    int              frames_done = 0;
    logic [NBIT-1:0] rx_byte     = '0;
    logic            rx_par      = 1'b0;
    logic [NBIT-1:0] exp_b;

    always @(negedge CLK) begin
        if (RESET) begin
            // A frame cut short by reset is lost; drop its expected byte.
            if (in_frame) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                in_frame = 1'b0;
            end
        end else begin
            if (!in_frame && TX == 1'b0) begin
                in_frame = 1'b1;
                tick_n   = 0;
                rx_byte  = '0;
                rx_par   = 1'b0;
            end
            if (in_frame && s_tick) begin
                tick_n++;
                if (tick_n <= DATA_END && ((tick_n - 1) % OS) == OS / 2) begin
                    dec_idx = (tick_n - 1) / OS;
                    if (dec_idx == 0) check("start_bit", 32'(TX), 0);
                    else if (dec_idx <= NBIT) rx_byte[dec_idx-1] = TX;
                    else rx_par = TX;
                end
                if (tick_n == DATA_END + SB_TICK / 2) check("stop_bit", 32'(TX), 1);
                if (tick_n == FRAME_TICKS) begin
                    check("tx_done_at_frame_end", 32'(tx_done), 1);
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_frame", 32'(exp_q.size()), 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_byte", 32'(rx_byte), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(rx_par), 32'(^exp_b));
`endif
                    end
                    frames_done++;
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        if (done_cnt < target) check(tag, 32'(done_cnt), 32'(target));
    endtask

    int r0, d0, f0;
    int bad_tx, bad_rd, bad_done, bad_state;
    int guard;

    initial begin
        // Reset state
        RESET = 1'b1;
        repeat (3) step();
        @(negedge CLK);
        check("reset_tx", 32'(TX), 1);
        check("reset_rd", 32'(RD_FIFO), 0);
        check("reset_done", 32'(tx_done), 0);
        check("reset_state", 32'(STATE), 0);
        step();
        RESET = 1'b0;

        // Idle with the FIFO empty
        bad_tx = 0; bad_rd = 0; bad_done = 0; bad_state = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (TX !== 1'b1) bad_tx++;
            if (RD_FIFO !== 1'b0) bad_rd++;
            if (tx_done !== 1'b0) bad_done++;
            if (STATE !== 3'd0) bad_state++;
        end
        check("idle_tx_not_high", 32'(bad_tx), 0);
        check("idle_rd_pulses", 32'(bad_rd), 0);
        check("idle_done_pulses", 32'(bad_done), 0);
        check("idle_state_nonzero", 32'(bad_state), 0);

        // Single frame 0x35
        step();
        r0 = rd_cnt; d0 = done_cnt; f0 = frames_done;
        send(8'h35);
        wait_done(d0 + 1, 2000, "timeout_0x35");
        repeat (10) step();
        check("single_rd_count", 32'(rd_cnt - r0), 1);
        check("single_done_count", 32'(done_cnt - d0), 1);
        check("single_frames", 32'(frames_done - f0), 1);

        // Three frames back to back
        r0 = rd_cnt; d0 = done_cnt; f0 = frames_done;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        wait_done(d0 + 3, 6000, "timeout_b2b");
        repeat (10) step();
        check("b2b_rd_count", 32'(rd_cnt - r0), 3);
        check("b2b_done_count", 32'(done_cnt - d0), 3);
        check("b2b_frames", 32'(frames_done - f0), 3);

        // Reset during data bit 3 of 0x41
        r0 = rd_cnt; d0 = done_cnt;
        send(8'h41);
        guard = 0;
        while (!(in_frame && tick_n >= 4 * OS + OS / 2) && guard < 2000) begin
            step();
            guard++;
        end
        check("reach_bit3", 32'(in_frame && tick_n >= 4 * OS + OS / 2), 1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset_tx", 32'(TX), 1);
        check("midreset_state", 32'(STATE), 0);
        step();
        RESET = 1'b0;
        repeat (400) step();
        check("midreset_rd_count", 32'(rd_cnt - r0), 1);
        check("midreset_done_count", 32'(done_cnt - d0), 0);

        // fifo_empty forced high in the middle of 0x39
        r0 = rd_cnt; d0 = done_cnt; f0 = frames_done;
        send(8'h39);
        guard = 0;
        while (!(in_frame && tick_n >= 40) && guard < 2000) begin
            step();
            guard++;
        end
        force_empty = 1'b1;
        send(8'h30);
        wait_done(d0 + 1, 2000, "timeout_0x39");
        repeat (200) step();
        check("forced_empty_rd_count", 32'(rd_cnt - r0), 1);
        force_empty = 1'b0;
        refresh_fifo();
        wait_done(d0 + 2, 2000, "timeout_0x30");
        repeat (10) step();
        check("released_rd_count", 32'(rd_cnt - r0), 2);
        check("released_frames", 32'(frames_done - f0), 2);

        // s_tick held high continuously, plus boundary data patterns
        tick_div = 1;
        r0 = rd_cnt; d0 = done_cnt; f0 = frames_done;
        send(8'h37);
        send(8'h00);
        send(8'hFF);
        wait_done(d0 + 3, 2000, "timeout_cont");
        repeat (10) step();
        check("cont_rd_count", 32'(rd_cnt - r0), 3);
        check("cont_frames", 32'(frames_done - f0), 3);
        check("sb_leftover", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
